// File: rtl/sig_avs_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
package sig_avs_pkg;
    typedef enum logic {IDLE, WAIT} state_e;

    localparam int ERR_CNT_W = 16;
    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;
    localparam logic [DATA_W-1:0] RD_FAULT = 32'h0;

    function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < BE_W; b++)
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/sig_avs_rdpipe.sv
// Fixed-latency read response pipeline; the output data stage holds its last
// valid word so readdata stays stable between responses.
module sig_avs_rdpipe #(
    parameter int LAT = 2,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    output logic [DW-1:0] out_data
);
    logic [LAT-1:0]         vld_q, vld_d;
    logic [LAT-1:0][DW-1:0] dat_q, dat_d;

    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = in_vld;
        if (in_vld) dat_d[0] = in_data;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld  = vld_q[LAT-1];
    assign out_data = dat_q[LAT-1];
endmodule

// File: rtl/sig_avs_mem.sv
// Avalon-MM responder over an on-chip word memory with programmable wait
// states, fixed read latency, byte-enabled writes and a fault counter.
module sig_avs_mem
    import sig_avs_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int READ_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          avs_s1_address,
    input  logic                 avs_s1_read,
    input  logic                 avs_s1_write,
    input  logic [DATA_W-1:0]    avs_s1_writedata,
    input  logic [BE_W-1:0]      avs_s1_byteenable,
    output logic                 avs_s1_waitrequest,
    output logic [DATA_W-1:0]    avs_s1_readdata,
    output logic                 avs_s1_readdatavalid,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e               state_q, state_d;
    logic [3:0]           wcnt_q, wcnt_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [DATA_W-1:0]    mem_q [DEPTH];

    logic [31:0]   word_addr;
    logic [AW-1:0] idx;
    logic          cmd, accept, oor, both, mem_we, rd_vld;
    logic [DATA_W-1:0] rd_data;

    assign word_addr = avs_s1_address >> 2;
    assign idx       = word_addr[AW-1:0];
    assign oor       = |(word_addr >> AW);
    assign cmd       = avs_s1_read | avs_s1_write;
    assign both      = avs_s1_read & avs_s1_write;
    // Gating with rst keeps waitrequest high throughout reset, even zero-wait.
    assign accept    = rst & cmd & (wcnt_q == 4'(WAIT_CYCLES));
    assign avs_s1_waitrequest = ~accept;

    assign mem_we  = accept & avs_s1_write & ~oor;
    assign rd_vld  = accept & avs_s1_read & ~avs_s1_write;
    assign rd_data = oor ? RD_FAULT : mem_q[idx];

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                if (cmd && !accept) begin
                    state_d = WAIT;
                    wcnt_d  = 4'd1;
                end
            end
            WAIT: begin
                if (!cmd || accept) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q < 4'(WAIT_CYCLES)) begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
        if (accept && (both || oor) && (err_q != '1))
            err_d = err_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[idx] <= be_merge(mem_q[idx], avs_s1_writedata, avs_s1_byteenable);
    end

    sig_avs_rdpipe #(.LAT(READ_LAT), .DW(DATA_W)) u_rdpipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_vld),
        .in_data  (rd_data),
        .out_vld  (avs_s1_readdatavalid),
        .out_data (avs_s1_readdata)
    );

    assign err_cnt = err_q;
endmodule

// File: tb/tb_sig_avs_mem.sv
// Directed bench for sig_avs_mem: one wait-state instance and one zero-wait instance.
module tb_sig_avs_mem;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr1, wdata1, rdata1, addr0, wdata0, rdata0;
    logic        rd1, wr1, wait1, rdv1, rd0, wr0, wait0, rdv0;
    logic [3:0]  be1, be0;
    logic [15:0] err1, err0;

    int checks = 0;
    int errors = 0;

    sig_avs_mem #(.DEPTH(1024), .WAIT_CYCLES(1), .READ_LAT(2)) dut1 (
        .clk(clk), .rst(rst),
        .avs_s1_address(addr1), .avs_s1_read(rd1), .avs_s1_write(wr1),
        .avs_s1_writedata(wdata1), .avs_s1_byteenable(be1),
        .avs_s1_waitrequest(wait1), .avs_s1_readdata(rdata1),
        .avs_s1_readdatavalid(rdv1), .err_cnt(err1)
    );

    sig_avs_mem #(.DEPTH(1024), .WAIT_CYCLES(0), .READ_LAT(2)) dut0 (
        .clk(clk), .rst(rst),
        .avs_s1_address(addr0), .avs_s1_read(rd0), .avs_s1_write(wr0),
        .avs_s1_writedata(wdata0), .avs_s1_byteenable(be0),
        .avs_s1_waitrequest(wait0), .avs_s1_readdata(rdata0),
        .avs_s1_readdatavalid(rdv0), .err_cnt(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command on dut1, return the number of waitrequest cycles seen.
    task automatic cmd1(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, output int nwait);
        nwait = 0;
        @(negedge clk);
        rd1 = r; wr1 = w; addr1 = a; wdata1 = d; be1 = b;
        #1;
        while (wait1 && nwait < 20) begin
            @(negedge clk); #1;
            nwait++;
        end
        if (nwait >= 20) chk("accept_timeout", 32'(nwait), 32'd0);
        @(posedge clk); #1;
        rd1 = 1'b0; wr1 = 1'b0;
    endtask

    // Read on dut1 and check the response lands exactly two edges after accept.
    task automatic read1(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int nw;
        cmd1(1'b1, 1'b0, a, 32'h0, 4'h0, nw);
        chk({tag, "_rdv_early"}, 32'(rdv1), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_rdv"}, 32'(rdv1), 32'd1);
        chk({tag, "_data"}, rdata1, exp);
        @(posedge clk); #1;
        chk({tag, "_rdv_pulse"}, 32'(rdv1), 32'd0);
    endtask

    initial begin
        int nw;
        rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0; be1 = 0;
        rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;
        repeat (2) @(negedge clk);
        chk("rst_wait", 32'(wait1), 32'd1);
        chk("rst_rdv", 32'(rdv1), 32'd0);
        chk("rst_rdata", rdata1, 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        rst = 1'b1;

        // Basic write/read with one wait state
        cmd1(1'b0, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF, nw);
        chk("wr_wait_cycles", 32'(nw), 32'd1);
        chk("idle_wait_high", 32'(wait1), 32'd1);
        read1("rd10", 32'h10, 32'hA5A5_1234);

        // Byte enables
        cmd1(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, nw);
        cmd1(1'b0, 1'b1, 32'h20, 32'h0000_0000, 4'b0101, nw);
        read1("rd20_be", 32'h20, 32'hFF00_FF00);
        cmd1(1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'h0, nw);
        read1("rd20_be0", 32'h20, 32'hFF00_FF00);

        // Read + write together: write done, read dropped, fault counted
        cmd1(1'b1, 1'b1, 32'h8, 32'd7, 4'hF, nw);
        chk("rw_err", 32'(err1), 32'd1);
        chk("rw_rdv0", 32'(rdv1), 32'd0);
        @(posedge clk); #1;
        chk("rw_rdv1", 32'(rdv1), 32'd0);
        @(posedge clk); #1;
        chk("rw_rdv2", 32'(rdv1), 32'd0);
        read1("rd8", 32'h8, 32'd7);

        // Out-of-range upper address bits
        cmd1(1'b0, 1'b1, 32'h0, 32'h55, 4'hF, nw);
        chk("err_unchanged", 32'(err1), 32'd1);
        cmd1(1'b0, 1'b1, 32'h8000_0000, 32'd9, 4'hF, nw);
        chk("oor_wr_err", 32'(err1), 32'd2);
        read1("rd0_kept", 32'h0, 32'h55);
        read1("oor_rd", 32'h8000_0000, 32'h0);
        chk("oor_rd_err", 32'(err1), 32'd3);

        // Zero-wait: preload, back-to-back reads
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr0 = 1'b1; addr0 = 32'(i * 4); wdata0 = 32'(i + 1); be0 = 4'hF;
            #1 chk("zw_wr_wait", 32'(wait0), 32'd0);
        end
        @(negedge clk);
        wr0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= 2) begin
                chk("zw_rdv", 32'(rdv0), 32'd1);
                chk("zw_data", rdata0, 32'(i - 1));
            end else begin
                chk("zw_rdv_lead", 32'(rdv0), 32'd0);
            end
            if (i < 4) begin
                rd0 = 1'b1; addr0 = 32'(i * 4);
                #1 chk("zw_rd_wait", 32'(wait0), 32'd0);
            end else begin
                rd0 = 1'b0;
            end
        end
        @(negedge clk);
        chk("zw_rdv_tail", 32'(rdv0), 32'd0);
        chk("zw_data_hold", rdata0, 32'd4);

        // Write immediately followed by read of the same word
        wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF; be0 = 4'hF;
        @(negedge clk);
        wr0 = 1'b0; rd0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        chk("wr_rd_rdv_early", 32'(rdv0), 32'd0);
        @(negedge clk);
        chk("wr_rd_rdv", 32'(rdv0), 32'd1);
        chk("wr_rd_data", rdata0, 32'hDEAD_BEEF);
        chk("zw_err", 32'(err0), 32'd0);

        // Reset with a read in flight
        cmd1(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, nw);
        @(negedge clk);
        rst = 1'b0;
        rd1 = 1'b1; rd0 = 1'b1;
        #1;
        chk("mid_rst_wait1", 32'(wait1), 32'd1);
        chk("mid_rst_wait0", 32'(wait0), 32'd1);
        chk("mid_rst_rdv", 32'(rdv1), 32'd0);
        chk("mid_rst_err", 32'(err1), 32'd0);
        chk("mid_rst_rdata", rdata1, 32'd0);
        @(negedge clk);
        rst = 1'b1; rd1 = 1'b0; rd0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rdv", 32'(rdv1), 32'd0);
        end
        read1("post_rst_rd", 32'h10, 32'hA5A5_1234);
        chk("post_rst_err", 32'(err1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sig_avs_mem.md
Name: sig_avs_mem

Overview:
- Avalon-MM slave (responder) backed by an on-chip word memory; the target end of the Signal DMA master port.
- Gives the DMA a deterministic memory to run against: programmable wait states on every command, fixed pipelined read latency, byte-enabled writes, and an error counter for protocol/range faults.
- Used as the Signal-block sample scratchpad and as the DMA verification target.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, 2..65536.
- WAIT_CYCLES, 1, cycles waitrequest stays high per command before acceptance (0..15).
- READ_LAT, 2, cycles from the read-accept edge to readdatavalid (1..8).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- avs_s1_address  in  32  byte address; word index = address[log2(DEPTH)+1:2]; bits [1:0] ignored.
- avs_s1_read  in  1  read request, held by master until accepted.
- avs_s1_write  in  1  write request, held by master until accepted.
- avs_s1_writedata  in  32  write data.
- avs_s1_byteenable  in  4  per-byte write enable; ignored on reads.
- avs_s1_waitrequest  out  1  high = command not accepted this cycle.
- avs_s1_readdata  out  32  read data, qualified by readdatavalid.
- avs_s1_readdatavalid  out  1  one-cycle pulse per accepted read.
- err_cnt  out  16  saturating count of faulted commands.

Behaviour:
- Reset (rst low, asynchronous):
  - waitrequest = 1, readdatavalid = 0, readdata = 0, err_cnt = 0.
  - Wait counter and read pipeline cleared.
  - Memory contents are not reset (zero-initialised for simulation only).
- Command present: cmd = read | write.
- Wait counter wcnt:
  - 0 when cmd = 0.
  - Increments each cycle cmd is high and wcnt < WAIT_CYCLES.
- accept = cmd & (wcnt == WAIT_CYCLES). waitrequest = ~accept (combinational); it is also high when idle.
- On the accept edge, wcnt returns to 0. A command held high after acceptance is treated as a new command and waits again.
- WAIT_CYCLES = 0: zero-wait; back-to-back accepts every cycle.
- Write at accept:
  - Memory word updated on the accept edge; only bytes with byteenable = 1 change.
  - byteenable = 0000 is a legal no-op.
- Read at accept:
  - Word sampled on the accept edge and entered into a READ_LAT-deep valid/data pipeline.
  - readdatavalid = 1 and readdata = word exactly READ_LAT cycles after the accept edge.
  - readdata holds its last value when not valid.
- Pipelining: a new read may be accepted while earlier reads are still in flight; responses return in order, one per accept.
- Ordering: a read accepted after a write to the same address returns the new data. Write-then-read on consecutive accepts must not return stale data.
- Read and write asserted together:
  - Write is performed, read is dropped (no readdatavalid).
  - err_cnt += 1.
- Out of range (word index >= DEPTH): unreachable by construction since DEPTH is a power of two. Address bits above the index field that are non-zero count as a fault:
  - Write is suppressed, err_cnt += 1.
  - Read still returns a response with readdata = 0, err_cnt += 1.
- err_cnt saturates at 0xFFFF.
- Reset mid-operation: in-flight reads are discarded with no late readdatavalid; waitrequest goes high immediately.
- State machine, 2 states:
  - IDLE -> WAIT when cmd = 1 and WAIT_CYCLES > 0.
  - WAIT -> IDLE on accept, or when cmd drops (no accept; not an error).
  - With WAIT_CYCLES = 0, accept happens in IDLE.

Decomposition:
- Package sig_avs_pkg holds:
  - State enum (IDLE, WAIT).
  - ERR_CNT_W = 16.
  - Fault readdata constant RD_FAULT = 32'h0.
  - Bus width constants (DATA_W = 32, BE_W = 4).
- Sub-module sig_avs_rdpipe: READ_LAT-deep shift register of {valid, data} with asynchronous clear; instanced once.

Test Plan:
- Reset, then WAIT_CYCLES=1, READ_LAT=2: write 0xA5A5_1234 to 0x10 with byteenable 1111 -> waitrequest high 1 cycle, then low 1 cycle. Read 0x10 -> readdatavalid exactly 2 cycles after the read accept, readdata 0xA5A5_1234.
- Byte enables: write 0xFFFF_FFFF to 0x20, then write 0x0000_0000 with byteenable 0101 -> read 0x20 returns 0xFF00_FF00.
- WAIT_CYCLES=0: 4 back-to-back reads of words 0..3 preloaded with 1,2,3,4 -> waitrequest never high with cmd present; four consecutive readdatavalid pulses carrying 1,2,3,4 in order.
- Read and write together at 0x8 with data 7 -> no readdatavalid, err_cnt = 1. Subsequent read of 0x8 returns 7.
- Address 0x8000_0000 (DEPTH=1024): write 9 -> memory unchanged, err_cnt += 1. Read -> readdatavalid with readdata 0, err_cnt += 1.
- Accept a read, then assert rst low 1 cycle later -> readdatavalid never asserts, waitrequest = 1 during reset, err_cnt = 0 after reset; normal operation resumes after release.
